// File: rtl/sram_ctrl_if.sv
// Purpose : bundles the MEM-stage request/response and the external SRAM pins of sram_ctrl.
// Latency : n/a (wiring only).
// Backpressure: ready low freezes the pipeline; request signals are held stable meanwhile.
// Ports   : wr_en/rd_en/address/st_val/rd_data/ready form the pipeline side;
//           sram_addr/sram_dq_out/sram_dq_in/sram_dq_oe/sram_we_n form the SRAM side.
interface sram_ctrl_if;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] st_val;
    logic [31:0] rd_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;

    // Controller side.
    modport slave (
        input  wr_en, rd_en, address, st_val, sram_dq_in,
        output rd_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

    // Pipeline + SRAM device side.
    modport master (
        output wr_en, rd_en, address, st_val, sram_dq_in,
        input  rd_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );
endinterface

// File: rtl/sram_ctrl.sv
// Purpose : turns a 32-bit MEM-stage load/store into two 16-bit SRAM half-accesses (low then high).
// Latency : request seen in IDLE at cycle 0 -> ready=1 at cycle 2*WAIT_CYCLES+1, fixed.
// Backpressure: ready is low while an access is in flight; requests are ignored outside IDLE.
// Ports   : clk, rst (synchronous, active-high); bus = sram_ctrl_if.slave carrying the
//           pipeline request/response and the SRAM address/data/strobe pins.
module sram_ctrl #(
    parameter int          WAIT_CYCLES = 5,
    parameter int unsigned DMEM_BASE   = 1024
) (
    input  logic       clk,
    input  logic       rst,
    sram_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [2:0] LAST_CNT = 3'(WAIT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [2:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic        r_op;        // 1 = write
    logic [31:0] r_rd_data;

    logic        w_req;
    logic        w_last;
    logic [16:0] w_word;

    assign w_req  = bus.rd_en | bus.wr_en;
    assign w_last = (r_cnt == LAST_CNT);
    // Word index relative to the data-memory base; wraps modulo 2^17 words.
    assign w_word = 17'((r_addr - 32'(DMEM_BASE)) >> 2);

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:  if (w_req)  w_next_state = S_LOW;
            S_LOW:   if (w_last) w_next_state = S_HIGH;
            S_HIGH:  if (w_last) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= 3'd0;
            r_addr    <= 32'd0;
            r_data    <= 32'd0;
            r_op      <= 1'b0;
            r_rd_data <= 32'd0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_cnt <= 3'd0;
                    if (w_req) begin
                        r_addr <= bus.address;
                        r_data <= bus.st_val;
                        r_op   <= bus.wr_en;   // write wins over read
                    end
                end
                S_LOW, S_HIGH: begin
                    r_cnt <= w_last ? 3'd0 : r_cnt + 3'd1;
                    // Sample the half-word on the last wait cycle, when SRAM data has settled.
                    if (w_last && !r_op) begin
                        if (r_state == S_LOW) r_rd_data[15:0]  <= bus.sram_dq_in;
                        else                  r_rd_data[31:16] <= bus.sram_dq_in;
                    end
                end
                default: r_cnt <= 3'd0;
            endcase
        end
    end

    // ---------------- output logic ----------------
    always_comb begin
        bus.sram_addr   = 18'd0;
        bus.sram_dq_out = 16'd0;
        bus.sram_dq_oe  = 1'b0;
        bus.sram_we_n   = 1'b1;
        bus.ready       = (r_state == S_DONE) || ((r_state == S_IDLE) && !w_req);
        bus.rd_data     = r_rd_data;
        // SRAM pins are parked while rst is asserted so an aborted write stops immediately.
        if (!rst) begin
            unique case (r_state)
                S_LOW: begin
                    bus.sram_addr = {w_word, 1'b0};
                    if (r_op) begin
                        bus.sram_dq_out = r_data[15:0];
                        bus.sram_dq_oe  = 1'b1;
                        // Strobe rises on the last cycle so the address is still stable at the rising edge.
                        bus.sram_we_n   = w_last;
                    end
                end
                S_HIGH: begin
                    bus.sram_addr = {w_word, 1'b1};
                    if (r_op) begin
                        bus.sram_dq_out = r_data[31:16];
                        bus.sram_dq_oe  = 1'b1;
                        bus.sram_we_n   = w_last;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Purpose : self-checking bench for sram_ctrl (default, WAIT=2 and WAIT=7 instances).
// Latency : n/a.
// Backpressure: requests are held until the access's ready cycle, as the pipeline would.
module tb_sram_ctrl;
    localparam int          W    = 5;
    localparam int unsigned BASE = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_ctrl_if sif ();
    sram_ctrl_if sif2 ();
    sram_ctrl_if sif7 ();

    sram_ctrl #(.WAIT_CYCLES(W), .DMEM_BASE(BASE)) dut  (.clk(clk), .rst(rst), .bus(sif));
    sram_ctrl #(.WAIT_CYCLES(2), .DMEM_BASE(BASE)) dut2 (.clk(clk), .rst(rst), .bus(sif2));
    sram_ctrl #(.WAIT_CYCLES(7), .DMEM_BASE(BASE)) dut7 (.clk(clk), .rst(rst), .bus(sif7));

    // mem: the SRAM device contents as written by the DUT's strobes.
    // ref_mem: what the SRAM should contain according to the access rules.
    bit [15:0] mem     [0:262143];
    bit [15:0] ref_mem [0:262143];

    assign sif.sram_dq_in  = mem[sif.sram_addr];
    assign sif2.sram_dq_in = 16'h0000;
    assign sif7.sram_dq_in = 16'h0000;

    // SRAM device: a write commits when the strobe rises while the address is unchanged.
    logic        prev_we_n = 1'b1;
    logic        prev_oe   = 1'b0;
    logic [17:0] prev_addr = '0;
    logic [15:0] prev_dq   = '0;
    always @(negedge clk) begin
        if (!prev_we_n && sif.sram_we_n && prev_oe && sif.sram_addr == prev_addr)
            mem[prev_addr] = prev_dq;
        prev_we_n = sif.sram_we_n;
        prev_oe   = sif.sram_dq_oe;
        prev_addr = sif.sram_addr;
        prev_dq   = sif.sram_dq_out;
    end

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] exp_rd = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_ready"}, 32'(sif.ready), 32'd1);
        chk({tag, "_addr"},  32'(sif.sram_addr), 32'd0);
        chk({tag, "_we_n"},  32'(sif.sram_we_n), 32'd1);
        chk({tag, "_oe"},    32'(sif.sram_dq_oe), 32'd0);
        chk({tag, "_rd"},    sif.rd_data, exp_rd);
    endtask

    // Idle cycles with no request; entered and left just after a rising edge.
    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            idle_chk("gap");
            @(posedge clk); #1;
        end
    endtask

    // One access from the pipeline's point of view. Called just after a rising edge with
    // the DUT in IDLE. rst_at>0 asserts reset during that cycle of the access.
    task automatic access(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d,
                          input int rst_at, input bit hold);
        logic [16:0] w;
        logic [17:0] lo_a, hi_a;
        int          half, c;
        w    = 17'((a - BASE) >> 2);
        lo_a = {w, 1'b0};
        hi_a = {w, 1'b1};
        sif.wr_en = wr; sif.rd_en = rd; sif.address = a; sif.st_val = d;
        @(negedge clk);
        chk("c0_ready", 32'(sif.ready), 32'd0);
        chk("c0_addr",  32'(sif.sram_addr), 32'd0);
        chk("c0_we_n",  32'(sif.sram_we_n), 32'd1);
        for (int k = 1; k <= 2 * W + 1; k++) begin
            @(posedge clk); #1;
            if (k == rst_at) rst = 1'b1;
            @(negedge clk);
            if (k == rst_at) begin
                chk("rst_we_n", 32'(sif.sram_we_n), 32'd1);
                chk("rst_oe",   32'(sif.sram_dq_oe), 32'd0);
                chk("rst_addr", 32'(sif.sram_addr), 32'd0);
                @(posedge clk); #1;
                rst = 1'b0; sif.wr_en = 1'b0; sif.rd_en = 1'b0;
                exp_rd = '0;
                if (wr && k > W) ref_mem[lo_a] = d[15:0];
                @(negedge clk);
                idle_chk("post_rst");
                chk("post_rst_mem_lo", 32'(mem[lo_a]), 32'(ref_mem[lo_a]));
                chk("post_rst_mem_hi", 32'(mem[hi_a]), 32'(ref_mem[hi_a]));
                @(posedge clk); #1;
                return;
            end
            if (k <= 2 * W) begin
                half = (k - 1) / W;
                c    = (k - 1) % W;
                chk("busy_ready", 32'(sif.ready), 32'd0);
                chk("busy_addr",  32'(sif.sram_addr), 32'((half == 0) ? lo_a : hi_a));
                chk("busy_oe",    32'(sif.sram_dq_oe), 32'(wr));
                chk("busy_we_n",  32'(sif.sram_we_n), (wr && c != W - 1) ? 32'd0 : 32'd1);
                if (wr) chk("busy_dq_out", 32'(sif.sram_dq_out), (half == 0) ? 32'(d[15:0]) : 32'(d[31:16]));
            end else begin
                if (!wr) exp_rd = {ref_mem[hi_a], ref_mem[lo_a]};
                chk("done_ready", 32'(sif.ready), 32'd1);
                chk("done_addr",  32'(sif.sram_addr), 32'd0);
                chk("done_we_n",  32'(sif.sram_we_n), 32'd1);
                chk("done_oe",    32'(sif.sram_dq_oe), 32'd0);
                chk("done_rd",    sif.rd_data, exp_rd);
            end
        end
        @(posedge clk); #1;
        if (!hold) begin
            sif.wr_en = 1'b0; sif.rd_en = 1'b0;
        end
        if (wr) begin
            ref_mem[lo_a] = d[15:0];
            ref_mem[hi_a] = d[31:16];
            chk("wr_mem_lo", 32'(mem[lo_a]), 32'(ref_mem[lo_a]));
            chk("wr_mem_hi", 32'(mem[hi_a]), 32'(ref_mem[hi_a]));
        end
    endtask

    initial begin
        int t2, t7;
        bit rw, rr;
        logic [31:0] ra;
        rst = 1'b1;
        sif.wr_en  = 0; sif.rd_en  = 0; sif.address  = '0; sif.st_val  = '0;
        sif2.wr_en = 0; sif2.rd_en = 0; sif2.address = '0; sif2.st_val = '0;
        sif7.wr_en = 0; sif7.rd_en = 0; sif7.address = '0; sif7.st_val = '0;
        mem[2] = 16'hF9F6; mem[3] = 16'hFFFF;
        ref_mem[2] = 16'hF9F6; ref_mem[3] = 16'hFFFF;

        // Reset state.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("reset_we_n", 32'(sif.sram_we_n), 32'd1);
            chk("reset_oe",   32'(sif.sram_dq_oe), 32'd0);
            chk("reset_addr", 32'(sif.sram_addr), 32'd0);
            chk("reset_rd",   sif.rd_data, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // Store right after reset, then load, then store leaving rd_data alone.
        access(1'b1, 1'b0, 32'd1024, 32'h0000060A, 0, 1'b0);
        access(1'b0, 1'b1, 32'd1028, 32'h0, 0, 1'b0);
        chk("load_value", exp_rd, 32'hFFFFF9F6);
        gap(1);
        access(1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, 0, 1'b0);
        // Simultaneous read+write performs the write.
        access(1'b1, 1'b1, 32'd1036, 32'h12345678, 0, 1'b0);
        // Back-to-back loads held continuously.
        access(1'b0, 1'b1, 32'd1036, 32'h0, 0, 1'b1);
        access(1'b0, 1'b1, 32'd1036, 32'h0, 0, 1'b0);
        chk("b2b_value", sif.rd_data, 32'h12345678);
        // Store aborted by reset in its 7th cycle.
        access(1'b1, 1'b0, 32'd1040, 32'hCAFEF00D, 7, 1'b0);
        gap(2);

        // WAIT=2 and WAIT=7 instances: idle behaviour, then latency of one load.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("p2_idle_ready", 32'(sif2.ready), 32'd1);
            chk("p2_idle_we_n",  32'(sif2.sram_we_n), 32'd1);
            chk("p7_idle_ready", 32'(sif7.ready), 32'd1);
            chk("p7_idle_addr",  32'(sif7.sram_addr), 32'd0);
            @(posedge clk); #1;
        end
        sif2.rd_en = 1'b1; sif2.address = 32'd1024;
        sif7.rd_en = 1'b1; sif7.address = 32'd1024;
        t2 = -1; t7 = -1;
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            if (sif2.ready && t2 < 0) t2 = k;
            if (sif7.ready && t7 < 0) t7 = k;
            @(posedge clk); #1;
            if (k == t2) sif2.rd_en = 1'b0;
            if (k == t7) sif7.rd_en = 1'b0;
        end
        sif2.rd_en = 1'b0; sif7.rd_en = 1'b0;
        chk("wait2_latency", 32'(t2), 32'd5);
        chk("wait7_latency", 32'(t7), 32'd15);

        // Randomised accesses, mostly in a small window so loads hit earlier stores.
        for (int i = 0; i < 40; i++) begin
            rw = 1'($urandom_range(0, 1));
            rr = rw ? 1'($urandom_range(0, 1)) : 1'b1;
            if ($urandom_range(0, 4) == 0) ra = $urandom;
            else ra = BASE + (32'($urandom_range(0, 31)) << 2) + 32'($urandom_range(0, 3));
            access(rw, rr, ra, $urandom, 0, 1'b0);
            gap($urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 5: SRAM cycles per 16-bit half-access; legal range 2..7.
REQ-002 Parameter DMEM_BASE, default 1024: byte address mapped to SRAM word 0.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 wr_en  input  1  MEM-stage store request (MEM_W).
REQ-006 rd_en  input  1  MEM-stage load request (MEM_R).
REQ-007 address  input  32  byte address from ALU result.
REQ-008 st_val  input  32  store data.
REQ-009 rd_data  output  32  load result, registered.
REQ-010 ready  output  1  high = access complete or no access; low = pipeline freeze.
REQ-011 sram_addr  output  18  SRAM half-word address.
REQ-012 sram_dq_out  output  16  write data to SRAM.
REQ-013 sram_dq_in  input  16  read data from SRAM.
REQ-014 sram_dq_oe  output  1  high = drive sram_dq_out onto the DQ bus.
REQ-015 sram_we_n  output  1  SRAM write strobe, active-low.

Function
REQ-016 The block SHALL implement the states IDLE, LOW, HIGH and DONE, using a 3-bit wait counter cnt.
REQ-017 In IDLE with rd_en or wr_en high, the block SHALL latch address, st_val and op (write if wr_en, so write wins when both are high), clear cnt and go to LOW.
REQ-018 In IDLE with no request, the block SHALL stay in IDLE.
REQ-019 LOW and HIGH SHALL each last exactly WAIT_CYCLES cycles, with cnt running 0..WAIT_CYCLES-1.
REQ-020 LOW SHALL go to HIGH, and HIGH SHALL go to DONE, at cnt=WAIT_CYCLES-1.
REQ-021 DONE SHALL last one cycle and then go to IDLE unconditionally.
REQ-022 Word index w SHALL equal (latched address - DMEM_BASE)>>2, truncated to 17 bits.
REQ-023 sram_addr SHALL be {w,1'b0} in LOW, {w,1'b1} in HIGH, and 0 in IDLE and DONE.
REQ-024 Address bits [1:0] SHALL be ignored; there is no range checking, and out-of-range addresses wrap modulo 2^17 words.
REQ-025 For a write, sram_dq_out SHALL be st_val[15:0] in LOW and st_val[31:16] in HIGH, with sram_dq_oe=1 throughout LOW and HIGH.
REQ-026 For a write, sram_we_n SHALL be 0 for cnt 0..WAIT_CYCLES-2 and 1 at cnt=WAIT_CYCLES-1, so the strobe rises before the address changes.
REQ-027 For a read, sram_dq_oe SHALL be 0 and sram_we_n SHALL be 1.
REQ-028 For a read, sram_dq_in SHALL be sampled into rd_data[15:0] at the last LOW cycle and into rd_data[31:16] at the last HIGH cycle.
REQ-029 rd_data SHALL hold its value until the next read overwrites it; writes SHALL NOT change rd_data.
REQ-030 ready SHALL be combinational: 1 in DONE, 1 in IDLE when rd_en=0 and wr_en=0, and 0 otherwise.
REQ-031 Latency SHALL be as follows: request seen in IDLE at cycle 0 gives ready=1 at cycle 2*WAIT_CYCLES+1 (cycle 11 at the default).
REQ-032 Access time SHALL be fixed and independent of data and address.
REQ-033 Request inputs SHALL be ignored outside IDLE; the pipeline holds them stable while ready=0.
REQ-034 A request present in the IDLE cycle after DONE SHALL be treated as a new access; back-to-back accesses therefore cost 2*WAIT_CYCLES+2 cycles each.
REQ-035 In IDLE and DONE, sram_dq_oe SHALL be 0 and sram_we_n SHALL be 1.

Reset
REQ-036 With rst high at a clock edge, the block SHALL set state=IDLE, cnt=0, rd_data=0 and clear the latched address, data and op.
REQ-037 While in reset, sram_we_n SHALL be 1, sram_dq_oe SHALL be 0 and sram_addr SHALL be 0.
REQ-038 Reset during LOW or HIGH SHALL abort the access; a partial write SHALL NOT be retried and any half already written stays in the SRAM.
REQ-039 After reset, ready SHALL follow REQ-030 immediately, so a request present on the first post-reset cycle gives ready=0.

Verification
REQ-040 Store: WAIT=5, wr_en=1, address=1024, st_val=0x0000060A -> sram_addr=0 with dq_out 0x060A for cycles 1-5, sram_addr=1 with dq_out 0x0000 for cycles 6-10, we_n low for 4 cycles per half, ready=1 at cycle 11.
REQ-041 Load: SRAM model returns 0xF9F6 at half-address 2 and 0xFFFF at half-address 3; rd_en=1, address=1028 -> rd_data=0xFFFFF9F6 and ready=1 at cycle 11; rd_data unchanged after a following store.
REQ-042 Simultaneous request: rd_en=wr_en=1 -> write cycle performed (dq_oe=1), rd_data unchanged.
REQ-043 Back-to-back: two loads held continuously -> ready pulses high for exactly one cycle at cycles 11 and 23.
REQ-044 Mid-operation reset: rst at cycle 7 of a store -> next cycle state IDLE, we_n=1, dq_oe=0, rd_data=0; high half not written.
REQ-045 Parameter sweep: WAIT_CYCLES=2 and 7 -> ready at cycles 5 and 15 respectively; no request -> ready stays 1 and SRAM stays idle.
